alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 57 +++++
 rtl/alu_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Command, ALU-drive and result bundle for alu_sequencer.
// slave = sequencer side, master = command source / ALU / result sink side.
interface alu_sequencer_if #(
    parameter int unsigned W = 16
) ();
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_opc;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         cmd_c;

    logic [2:0]   alu_opc;
    logic [W-1:0] alu_A;
    logic [W-1:0] alu_B;
    logic         alu_C;
    logic [W-1:0] alu_W;
    logic         alu_zero;
    logic         alu_neg;

    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_W;
    logic         res_zero;
    logic         res_neg;
    logic [2:0]   res_opc;
    logic         busy;
`ifdef ALU_SEQ_ERR_EN
    logic         res_err;
`endif

    modport slave (
        input  cmd_valid, cmd_opc, cmd_a, cmd_b, cmd_c,
        input  alu_W, alu_zero, alu_neg,
        input  res_ready,
        output cmd_ready,
        output alu_opc, alu_A, alu_B, alu_C,
        output res_valid, res_W, res_zero, res_neg, res_opc,
        output busy
`ifdef ALU_SEQ_ERR_EN
        , output res_err
`endif
    );

    modport master (
        output cmd_valid, cmd_opc, cmd_a, cmd_b, cmd_c,
        output alu_W, alu_zero, alu_neg,
        output res_ready,
        input  cmd_ready,
        input  alu_opc, alu_A, alu_B, alu_C,
        input  res_valid, res_W, res_zero, res_neg, res_opc,
        input  busy
`ifdef ALU_SEQ_ERR_EN
        , input res_err
`endif
    );
endinterface

// File: rtl/alu_sequencer.sv
// Command FIFO feeding an IDLE/ISSUE/HOLD sequencer around an external combinational ALU.
// Optional macro ALU_SEQ_ERR_EN: opcode 7 is trapped (not issued) and flagged on res_err.
module alu_sequencer #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4
) (
    input logic            clk,
    input logic            rst_n,
    alu_sequencer_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [2:0]   opc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
    } entry_t;

    typedef enum logic [1:0] {StIdle, StIssue, StHold} state_e;

    state_e        state_q;
    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    entry_t        head;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
`ifdef ALU_SEQ_ERR_EN
    logic          trap_q;
`endif

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
    assign head  = mem_q[rd_ptr_q];

    // Pop decisions use the pre-edge count, so a same-cycle push never bypasses the FIFO.
    assign push = bus.cmd_valid && !full;
    assign pop  = !empty && ((state_q == StIdle) || ((state_q == StHold) && bus.res_ready));

    assign bus.cmd_ready = !full;
    assign bus.busy      = !empty || (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{opc: bus.cmd_opc, a: bus.cmd_a, b: bus.cmd_b, c: bus.cmd_c};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            bus.alu_opc   <= '0;
            bus.alu_A     <= '0;
            bus.alu_B     <= '0;
            bus.alu_C     <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_W     <= '0;
            bus.res_zero  <= 1'b0;
            bus.res_neg   <= 1'b0;
            bus.res_opc   <= '0;
`ifdef ALU_SEQ_ERR_EN
            trap_q        <= 1'b0;
            bus.res_err   <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (pop) state_q <= StIssue;
                end
                StIssue: begin
                    bus.res_valid <= 1'b1;
                    state_q       <= StHold;
`ifdef ALU_SEQ_ERR_EN
                    if (trap_q) begin
                        bus.res_W    <= '0;
                        bus.res_zero <= 1'b1;
                        bus.res_neg  <= 1'b0;
                        bus.res_opc  <= 3'd7;
                        bus.res_err  <= 1'b1;
                    end else begin
                        bus.res_W    <= bus.alu_W;
                        bus.res_zero <= bus.alu_zero;
                        bus.res_neg  <= bus.alu_neg;
                        bus.res_opc  <= bus.alu_opc;
                        bus.res_err  <= 1'b0;
                    end
`else
                    bus.res_W    <= bus.alu_W;
                    bus.res_zero <= bus.alu_zero;
                    bus.res_neg  <= bus.alu_neg;
                    bus.res_opc  <= bus.alu_opc;
`endif
                end
                StHold: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        state_q       <= pop ? StIssue : StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // ALU drive only changes on a pop; it holds the last issued command otherwise.
            if (pop) begin
`ifdef ALU_SEQ_ERR_EN
                trap_q <= (head.opc == 3'd7);
                if (head.opc != 3'd7) begin
                    bus.alu_opc <= head.opc;
                    bus.alu_A   <= head.a;
                    bus.alu_B   <= head.b;
                    bus.alu_C   <= head.c;
                end
`else
                bus.alu_opc <= head.opc;
                bus.alu_A   <= head.a;
                bus.alu_B   <= head.b;
                bus.alu_C   <= head.c;
`endif
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: in-order result scoreboard plus hand-computed checks.
module tb_alu_sequencer;
    localparam int unsigned W = 16;

    typedef struct packed {
        logic [2:0]   opc;
        logic [W-1:0] w;
        logic         z;
        logic         n;
        logic         e;
    } exp_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   errors;
    int   cyc;
    exp_t exp_q[$];

    alu_sequencer_if #(.W(W)) ifc ();

    alu_sequencer #(.W(W), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    // External ALU: 0 neg, 1 inc, 2 add+carry, 3 sub, 4 and, 5 or, 6 xor, 7 not.
    function automatic logic [W-1:0] alu_f(input logic [2:0] opc, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic c);
        case (opc)
            3'd0:    return W'(0) - a;
            3'd1:    return a + W'(1);
            3'd2:    return a + b + W'(c);
            3'd3:    return a - b;
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    function automatic exp_t expect_of(input logic [2:0] opc, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input logic c);
        exp_t r;
        r.opc = opc;
        r.w   = alu_f(opc, a, b, c);
        r.z   = (r.w == '0);
        r.n   = r.w[W-1];
        r.e   = 1'b0;
`ifdef ALU_SEQ_ERR_EN
        if (opc == 3'd7) begin
            r.w = '0;
            r.z = 1'b1;
            r.n = 1'b0;
            r.e = 1'b1;
        end
`endif
        return r;
    endfunction

    assign ifc.alu_W    = alu_f(ifc.alu_opc, ifc.alu_A, ifc.alu_B, ifc.alu_C);
    assign ifc.alu_zero = (ifc.alu_W == '0);
    assign ifc.alu_neg  = ifc.alu_W[W-1];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: inputs change 1 time unit after posedge, so negedge sees the handshake values.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (ifc.res_valid) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_result", 32'(ifc.res_valid), 32'(0));
                end else begin
                    check("sb_res_W", 32'(ifc.res_W), 32'(exp_q[0].w));
                    check("sb_res_zero", 32'(ifc.res_zero), 32'(exp_q[0].z));
                    check("sb_res_neg", 32'(ifc.res_neg), 32'(exp_q[0].n));
                    check("sb_res_opc", 32'(ifc.res_opc), 32'(exp_q[0].opc));
`ifdef ALU_SEQ_ERR_EN
                    check("sb_res_err", 32'(ifc.res_err), 32'(exp_q[0].e));
`endif
                    if (ifc.res_ready) void'(exp_q.pop_front());
                end
            end
            if (ifc.cmd_valid && ifc.cmd_ready) begin
                exp_q.push_back(expect_of(ifc.cmd_opc, ifc.cmd_a, ifc.cmd_b, ifc.cmd_c));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c);
        logic ok;
        ok = 1'b0;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_opc   = opc;
        ifc.cmd_a     = a;
        ifc.cmd_b     = b;
        ifc.cmd_c     = c;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = ifc.cmd_ready;
            tick();
        end
        ifc.cmd_valid = 1'b0;
        check("send_accepted", 32'(ok), 32'(1));
    endtask

    task automatic wait_result(input string name, output logic [W-1:0] w, output logic z,
                               output logic n, output logic [2:0] opc);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (ifc.res_valid) found = 1'b1;
            else tick();
        end
        check(name, 32'(found), 32'(1));
        w   = ifc.res_W;
        z   = ifc.res_zero;
        n   = ifc.res_neg;
        opc = ifc.res_opc;
        tick();
    endtask

    initial begin
        logic [W-1:0] w;
        logic         z;
        logic         n;
        logic [2:0]   o;
        logic [2:0]   bp_opc [6];
        logic [2:0]   got_opc [6];
        int           got;
        int           last;
        int           seen;
        logic         accepted;
        logic         take;

        vectors = 0;
        errors  = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_opc   = '0;
        ifc.cmd_a     = '0;
        ifc.cmd_b     = '0;
        ifc.cmd_c     = 1'b0;
        ifc.res_ready = 1'b1;
        tick();
        tick();

        // Reset values
        check("rst_res_valid", 32'(ifc.res_valid), 32'(0));
        check("rst_cmd_ready", 32'(ifc.cmd_ready), 32'(1));
        check("rst_busy", 32'(ifc.busy), 32'(0));
        check("rst_alu_A", 32'(ifc.alu_A), 32'(0));
        check("rst_alu_opc", 32'(ifc.alu_opc), 32'(0));
        check("rst_res_W", 32'(ifc.res_W), 32'(0));
        rst_n = 1'b1;
        tick();

        // Add with latency: accepted at edge k, popped k+1, result after k+2
        send(3'd2, 16'h0005, 16'h0003, 1'b1);
        check("lat_k_valid", 32'(ifc.res_valid), 32'(0));
        check("lat_k_busy", 32'(ifc.busy), 32'(1));
        tick();
        check("lat_k1_valid", 32'(ifc.res_valid), 32'(0));
        check("lat_k1_alu_A", 32'(ifc.alu_A), 32'h5);
        check("lat_k1_alu_opc", 32'(ifc.alu_opc), 32'd2);
        tick();
        check("lat_k2_valid", 32'(ifc.res_valid), 32'(1));
        check("add_res_W", 32'(ifc.res_W), 32'h9);
        check("add_zero", 32'(ifc.res_zero), 32'(0));
        check("add_neg", 32'(ifc.res_neg), 32'(0));
        check("add_opc", 32'(ifc.res_opc), 32'd2);
        tick();
        check("add_done_valid", 32'(ifc.res_valid), 32'(0));
        check("add_done_busy", 32'(ifc.busy), 32'(0));
        check("hold_alu_A", 32'(ifc.alu_A), 32'h5);

        // Negate
        send(3'd0, 16'h0001, 16'h0000, 1'b0);
        wait_result("neg1_seen", w, z, n, o);
        check("neg1_W", 32'(w), 32'hFFFF);
        check("neg1_neg", 32'(n), 32'(1));
        check("neg1_zero", 32'(z), 32'(0));
        send(3'd0, 16'h0000, 16'h0000, 1'b0);
        wait_result("neg0_seen", w, z, n, o);
        check("neg0_W", 32'(w), 32'h0);
        check("neg0_zero", 32'(z), 32'(1));

        // Opcode 7
        send(3'd2, 16'h0AAA, 16'h0000, 1'b0);
        wait_result("pre7_seen", w, z, n, o);
        send(3'd7, 16'h1234, 16'h0000, 1'b0);
        wait_result("op7_seen", w, z, n, o);
        check("op7_opc", 32'(o), 32'd7);
`ifdef ALU_SEQ_ERR_EN
        check("op7_W", 32'(w), 32'h0);
        check("op7_zero", 32'(z), 32'(1));
        check("op7_alu_A_kept", 32'(ifc.alu_A), 32'h0AAA);
`else
        check("op7_W", 32'(w), 32'hEDCB);
        check("op7_neg", 32'(n), 32'(1));
        check("op7_alu_A", 32'(ifc.alu_A), 32'h1234);
`endif
        repeat (2) tick();

        // Backpressure: 5 accepted, 6th refused while the result is held
        bp_opc = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        ifc.res_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(bp_opc[i], W'(16'h0100 * i + 7), W'(i), 1'b0);
        ifc.cmd_valid = 1'b1;
        ifc.cmd_opc   = bp_opc[5];
        ifc.cmd_a     = 16'h0555;
        ifc.cmd_b     = 16'h0005;
        ifc.cmd_c     = 1'b0;
        check("bp_full_ready", 32'(ifc.cmd_ready), 32'(0));
        check("bp_busy", 32'(ifc.busy), 32'(1));
        check("bp_hold_valid", 32'(ifc.res_valid), 32'(1));
        repeat (3) tick();
        check("bp_still_full", 32'(ifc.cmd_ready), 32'(0));
        check("bp_held_opc", 32'(ifc.res_opc), 32'(bp_opc[0]));
        check("bp_held_W", 32'(ifc.res_W), 32'h0008);
        ifc.res_ready = 1'b1;
        got = 0;
        accepted = 1'b0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (ifc.res_valid) begin
                got_opc[got] = ifc.res_opc;
                got++;
            end
            take = ifc.cmd_valid && ifc.cmd_ready;
            tick();
            if (take) begin
                ifc.cmd_valid = 1'b0;
                accepted = 1'b1;
            end
        end
        check("bp_result_count", 32'(got), 32'd6);
        check("bp_6th_accepted", 32'(accepted), 32'(1));
        for (int i = 0; i < 6; i++) check("bp_order", 32'(got_opc[i]), 32'(bp_opc[i]));
        repeat (2) tick();

        // Streaming across pointer wrap
        got  = 0;
        last = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(3'(i), W'(16'h0111 * (i + 1)), W'(16'h0021 * i), 1'(i));
            end
            begin
                for (int c = 0; c < 80 && got < 8; c++) begin
                    tick();
                    if (ifc.res_valid) begin
                        check("stream_opc", 32'(ifc.res_opc), 32'(got));
                        if (got > 0) check("stream_gap", 32'(cyc - last), 32'd2);
                        last = cyc;
                        got++;
                    end
                end
            end
        join
        check("stream_count", 32'(got), 32'd8);
        repeat (2) tick();
        check("stream_idle_busy", 32'(ifc.busy), 32'(0));

        // Reset while holding with 3 queued
        ifc.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(3'd5, W'(16'h00F0 + i), W'(16'h0F00), 1'b0);
        tick();
        check("rst_pre_valid", 32'(ifc.res_valid), 32'(1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_valid", 32'(ifc.res_valid), 32'(0));
        check("rst_mid_busy", 32'(ifc.busy), 32'(0));
        check("rst_mid_ready", 32'(ifc.cmd_ready), 32'(1));
        ifc.res_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (ifc.res_valid) seen++;
        end
        check("rst_no_results", 32'(seen), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
